// File: rtl/vdc_pkg.sv
// Shared definitions for the vertical display controller: frame-walk states,
// CRTC register indices and the vsync width decode.
package vdc_pkg;

    typedef enum logic {
        ROWS   = 1'b0,
        ADJUST = 1'b1
    } vdc_state_e;

    localparam logic [3:0] R3_IDX = 4'd3;
    localparam logic [3:0] R4_IDX = 4'd4;
    localparam logic [3:0] R5_IDX = 4'd5;
    localparam logic [3:0] R6_IDX = 4'd6;
    localparam logic [3:0] R7_IDX = 4'd7;
    localparam logic [3:0] R9_IDX = 4'd9;

    // A programmed width of zero selects the maximum of 16 lines.
    function automatic logic [4:0] vsync_lines(input logic [3:0] vw);
        if (vw == 4'd0) begin
            return 5'd16;
        end else begin
            return {1'b0, vw};
        end
    endfunction

endpackage

// File: rtl/vdc_signals_v_if.sv
// Vertical timing register bundle, driven by the register file and consumed
// by the vertical signal generator.
interface vdc_signals_v_if;

    logic [7:0] reg_vt;
    logic [4:0] reg_vta;
    logic [7:0] reg_vd;
    logic [7:0] reg_vp;
    logic [3:0] reg_vw;
    logic [4:0] reg_ctv;

    modport master (output reg_vt, reg_vta, reg_vd, reg_vp, reg_vw, reg_ctv);
    modport slave  (input  reg_vt, reg_vta, reg_vd, reg_vp, reg_vw, reg_ctv);

endinterface

// File: rtl/vdc_vsync_gen.sv
// Vsync pulse generator: armed by the row counter, edges aligned to hsync start,
// width counted in scan lines.
module vdc_vsync_gen
    import vdc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       arm,
    input  logic       hSyncStart,
    input  logic [3:0] reg_vw,
    output logic       vsync,
    output logic       vsync_nxt
);

    logic       vs_r;
    logic       armed_r;
    logic [4:0] cnt_r;
    logic       vs_nxt_s;
    logic       armed_nxt_s;
    logic [4:0] cnt_nxt_s;
    logic       start_s;

    // Next-state for the pulse; cnt_r holds lines remaining after the current one.
    always_comb begin
        vs_nxt_s  = vs_r;
        cnt_nxt_s = cnt_r;
        start_s   = 1'b0;
        if (enable && hSyncStart) begin
            if (vs_r) begin
                if (cnt_r == 5'd0) begin
                    vs_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r - 5'd1;
                end
            end else if (armed_r) begin
                vs_nxt_s  = 1'b1;
                cnt_nxt_s = vsync_lines(reg_vw) - 5'd1;
                start_s   = 1'b1;
            end else begin
                vs_nxt_s = 1'b0;
            end
        end else begin
            vs_nxt_s = vs_r;
        end
        armed_nxt_s = arm | (armed_r & ~start_s);
    end

    // Pulse state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_r    <= 1'b0;
            armed_r <= 1'b0;
            cnt_r   <= 5'd0;
        end else begin
            vs_r    <= vs_nxt_s;
            armed_r <= armed_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign vsync     = vs_r;
    assign vsync_nxt = vs_nxt_s;

endmodule

// File: rtl/vdc_signals_v.sv
// Vertical timing for the video display controller: row/line counters,
// vertical total adjust, display enable, vsync and blanking.
module vdc_signals_v
    import vdc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               endLine,
    input  logic               hSyncStart,
    vdc_signals_v_if.slave     regs,
    output logic [7:0]         row,
    output logic [4:0]         line,
    output logic               newRow,
    output logic               newFrame,
    output logic               vdispen,
    output logic               vsync,
    output logic               vblank
);

    vdc_state_e state_r;
    vdc_state_e state_nxt_s;
    logic [7:0] row_r;
    logic [7:0] row_nxt_s;
    logic [4:0] line_r;
    logic [4:0] line_nxt_s;
    logic [4:0] adj_r;
    logic [4:0] adj_nxt_s;
    logic       new_row_r;
    logic       new_frame_r;
    logic       vdispen_r;
    logic       vdispen_nxt_s;
    logic       vblank_r;
    logic       row_chg_s;
    logic       wrap_s;
    logic       arm_s;
    logic       vsync_nxt_s;

    // Frame walk; >= compares keep a shrunk total from running to counter wrap.
    always_comb begin
        state_nxt_s = state_r;
        row_nxt_s   = row_r;
        line_nxt_s  = line_r;
        adj_nxt_s   = adj_r;
        row_chg_s   = 1'b0;
        wrap_s      = 1'b0;
        if (enable && endLine) begin
            case (state_r)
                ROWS: begin
                    if (line_r >= regs.reg_ctv) begin
                        line_nxt_s = 5'd0;
                        row_chg_s  = 1'b1;
                        if ((row_r >= regs.reg_vt) && (regs.reg_vta == 5'd0)) begin
                            wrap_s = 1'b1;
                        end else if (row_r >= regs.reg_vt) begin
                            state_nxt_s = ADJUST;
                            adj_nxt_s   = 5'd0;
                            row_nxt_s   = regs.reg_vt + 8'd1;
                        end else begin
                            row_nxt_s = row_r + 8'd1;
                        end
                    end else begin
                        line_nxt_s = line_r + 5'd1;
                    end
                end
                ADJUST: begin
                    if (({1'b0, adj_r} + 6'd1) >= {1'b0, regs.reg_vta}) begin
                        wrap_s    = 1'b1;
                        row_chg_s = 1'b1;
                    end else begin
                        adj_nxt_s  = adj_r + 5'd1;
                        line_nxt_s = line_r + 5'd1;
                    end
                end
                default: begin
                    wrap_s    = 1'b1;
                    row_chg_s = 1'b1;
                end
            endcase
            if (wrap_s) begin
                state_nxt_s = ROWS;
                row_nxt_s   = 8'd0;
                line_nxt_s  = 5'd0;
                adj_nxt_s   = 5'd0;
            end else begin
                state_nxt_s = state_nxt_s;
            end
        end else begin
            row_chg_s = 1'b0;
        end
    end

    // Display enable and vsync arming follow the row about to be entered.
    always_comb begin
        vdispen_nxt_s = vdispen_r;
        if (wrap_s) begin
            vdispen_nxt_s = (regs.reg_vd != 8'd0);
        end else if (row_chg_s && (row_nxt_s == regs.reg_vd)) begin
            vdispen_nxt_s = 1'b0;
        end else begin
            vdispen_nxt_s = vdispen_r;
        end
        arm_s = row_chg_s && (state_nxt_s == ROWS) && (row_nxt_s == regs.reg_vp);
    end

    vdc_vsync_gen u_vsync_gen (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .arm        (arm_s),
        .hSyncStart (hSyncStart),
        .reg_vw     (regs.reg_vw),
        .vsync      (vsync),
        .vsync_nxt  (vsync_nxt_s)
    );

    // Counter, state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ROWS;
            row_r       <= 8'd0;
            line_r      <= 5'd0;
            adj_r       <= 5'd0;
            new_row_r   <= 1'b0;
            new_frame_r <= 1'b0;
            vdispen_r   <= 1'b0;
            vblank_r    <= 1'b1;
        end else if (enable) begin
            state_r     <= state_nxt_s;
            row_r       <= row_nxt_s;
            line_r      <= line_nxt_s;
            adj_r       <= adj_nxt_s;
            new_row_r   <= row_chg_s;
            new_frame_r <= wrap_s;
            vdispen_r   <= vdispen_nxt_s;
            vblank_r    <= ~vdispen_nxt_s | vsync_nxt_s;
        end else begin
            new_row_r   <= 1'b0;
            new_frame_r <= 1'b0;
        end
    end

    assign row      = row_r;
    assign line     = line_r;
    assign newRow   = new_row_r;
    assign newFrame = new_frame_r;
    assign vdispen  = vdispen_r;
    assign vblank   = vblank_r;

endmodule

// File: tb/tb_vdc_signals_v.sv
// Directed self-checking bench for vdc_signals_v: frame walk, adjust lines,
// vsync width, register reprogramming, clock enable and reset.
module tb_vdc_signals_v;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       endLine = 1'b0;
    logic       hSyncStart = 1'b0;
    logic [7:0] row;
    logic [4:0] line;
    logic       newRow, newFrame, vdispen, vsync, vblank;

    int n_checks = 0;
    int n_fail   = 0;

    vdc_signals_v_if regs_if ();

    vdc_signals_v dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .endLine    (endLine),
        .hSyncStart (hSyncStart),
        .regs       (regs_if),
        .row        (row),
        .line       (line),
        .newRow     (newRow),
        .newFrame   (newFrame),
        .vdispen    (vdispen),
        .vsync      (vsync),
        .vblank     (vblank)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan line: hsync start, idle, end of line. Samples vsync/vblank after hsync.
    task automatic do_line(output logic vs_mid, output logic vb_mid);
        hSyncStart = 1'b1;
        tick();
        vs_mid = vsync;
        vb_mid = vblank;
        hSyncStart = 1'b0;
        tick();
        endLine = 1'b1;
        tick();
        endLine = 1'b0;
    endtask

    task automatic set_regs(input logic [7:0] vt, input logic [4:0] vta, input logic [7:0] vd,
                            input logic [7:0] vp, input logic [3:0] vw, input logic [4:0] ctv);
        regs_if.reg_vt  = vt;
        regs_if.reg_vta = vta;
        regs_if.reg_vd  = vd;
        regs_if.reg_vp  = vp;
        regs_if.reg_vw  = vw;
        regs_if.reg_ctv = ctv;
    endtask

    initial begin
        logic vs, vb;
        int   n;
        set_regs(8'd3, 5'd0, 8'd2, 8'd9, 4'd3, 5'd1);
        tick();
        tick();
        check_eq("rst_row", row, 0);
        check_eq("rst_line", line, 0);
        check_eq("rst_newRow", newRow, 0);
        check_eq("rst_newFrame", newFrame, 0);
        check_eq("rst_vdispen", vdispen, 0);
        check_eq("rst_vsync", vsync, 0);
        check_eq("rst_vblank", vblank, 1);
        reset = 1'b0;
        enable = 1'b1;

        // First frame: vdispen stays low until the wrap.
        for (int i = 1; i <= 8; i++) begin
            do_line(vs, vb);
            if (i < 8) check_eq("f0_vdispen", vdispen, 0);
        end
        check_eq("f0_newFrame", newFrame, 1);
        check_eq("f0_row", row, 0);
        check_eq("f0_vdispen_set", vdispen, 1);
        check_eq("f0_vblank", vblank, 0);
        tick();
        check_eq("f0_newFrame_clr", newFrame, 0);
        check_eq("f0_newRow_clr", newRow, 0);

        // Plain frame: 4 rows of 2 lines, display on rows 0-1.
        for (int i = 1; i <= 8; i++) begin
            do_line(vs, vb);
            n = i % 8;
            check_eq("f1_row", row, n / 2);
            check_eq("f1_line", line, n % 2);
            check_eq("f1_newRow", newRow, (n % 2) == 0);
            check_eq("f1_newFrame", newFrame, n == 0);
            check_eq("f1_vdispen", vdispen, (n / 2) < 2);
            check_eq("f1_vblank", vblank, (n / 2) >= 2);
        end

        // Vertical adjust of 3 lines: row holds at 4.
        regs_if.reg_vta = 5'd3;
        for (int i = 1; i <= 11; i++) begin
            do_line(vs, vb);
            n = i % 11;
            check_eq("adj_row", row, (n >= 8) ? 4 : n / 2);
            check_eq("adj_line", line, (n >= 8) ? n - 8 : n % 2);
            check_eq("adj_newFrame", newFrame, n == 0);
            check_eq("adj_vdispen", vdispen, n < 4);
        end

        // Vsync at row 2, 3 lines wide, rising at the first hsync of row 2.
        regs_if.reg_vta = 5'd0;
        regs_if.reg_vp  = 8'd2;
        for (int i = 0; i < 8; i++) begin
            do_line(vs, vb);
            check_eq("vs3_vsync", vs, (i >= 4) && (i <= 6));
            check_eq("vs3_vblank", vb, i >= 4);
        end
        check_eq("vs3_newFrame", newFrame, 1);

        // vw=0 means 16 lines; vp=0 arms at the frame wrap into the next frame.
        set_regs(8'd9, 5'd0, 8'd2, 8'd0, 4'd0, 5'd1);
        for (int i = 0; i < 40; i++) begin
            do_line(vs, vb);
            check_eq("vs16_vsync", vs, (i >= 20) && (i <= 35));
        end
        check_eq("vs16_newFrame", newFrame, 1);

        // Shrinking the character height mid-row ends the row at the next line end.
        regs_if.reg_ctv = 5'd7;
        for (int i = 0; i < 5; i++) do_line(vs, vb);
        check_eq("ctv_pre_line", line, 5);
        regs_if.reg_ctv = 5'd2;
        do_line(vs, vb);
        check_eq("ctv_row", row, 1);
        check_eq("ctv_line", line, 0);
        check_eq("ctv_newRow", newRow, 1);
        for (int i = 0; i < 4; i++) do_line(vs, vb);
        check_eq("pre_row", row, 2);
        check_eq("pre_line", line, 1);
        check_eq("pre_vsync", vsync, 1);

        // Clock enable low: inputs pulse but nothing moves.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            endLine    = (i % 3) == 0;
            hSyncStart = (i % 3) == 1;
            tick();
            check_eq("en_row", row, 2);
            check_eq("en_line", line, 1);
            check_eq("en_pulse", {30'd0, newRow, newFrame}, 0);
            check_eq("en_vsync", vsync, 1);
        end
        endLine    = 1'b0;
        hSyncStart = 1'b0;

        // Reset mid-vsync with enable low still takes effect.
        reset = 1'b1;
        tick();
        check_eq("mrst_row", row, 0);
        check_eq("mrst_line", line, 0);
        check_eq("mrst_vsync", vsync, 0);
        check_eq("mrst_vblank", vblank, 1);
        check_eq("mrst_vdispen", vdispen, 0);
        reset  = 1'b0;
        enable = 1'b1;

        // Restart, then drop vt below the current row: next boundary wraps.
        set_regs(8'd9, 5'd0, 8'd2, 8'd15, 4'd3, 5'd1);
        for (int i = 0; i < 6; i++) begin
            do_line(vs, vb);
            check_eq("rs_vdispen", vdispen, 0);
        end
        check_eq("rs_row", row, 3);
        regs_if.reg_vt = 8'd1;
        do_line(vs, vb);
        check_eq("vt_line", line, 1);
        do_line(vs, vb);
        check_eq("vt_newFrame", newFrame, 1);
        check_eq("vt_row", row, 0);
        check_eq("vt_vdispen", vdispen, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vdc_signals_v.md
VDC_SIGNALS_V -- requirements
Module: vdc_signals_v

Interface
REQ-001 SHALL have port: clk  input  1  pixel clock; all state updates on its rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: enable  input  1  clock enable; when low, all state holds.
REQ-004 SHALL have port: endLine  input  1  pulse on the last pixel of a scan line (endCol with col==R0, from horizontal stage).
REQ-005 SHALL have port: hSyncStart  input  1  pulse at horizontal sync start; aligns vsync edges.
REQ-006 SHALL have port: reg_vt  input  8  R4, vertical total rows minus 1.
REQ-007 SHALL have port: reg_vta  input  5  R5[4:0], vertical total adjust in lines.
REQ-008 SHALL have port: reg_vd  input  8  R6, vertical displayed rows.
REQ-009 SHALL have port: reg_vp  input  8  R7, vertical sync position row.
REQ-010 SHALL have port: reg_vw  input  4  R3[7:4], vsync width in lines; 0 means 16.
REQ-011 SHALL have port: reg_ctv  input  5  R9[4:0], character total vertical minus 1.
REQ-012 SHALL have ports: row  output  8  current row; line  output  5  current line within row.
REQ-013 SHALL have ports: newRow, newFrame  output  1  one-cycle pulses at row start and frame start.
REQ-014 SHALL have ports: vdispen  output  1  vertical display enable; vsync, vblank  output  1  sync/blanking.

Function
REQ-015 SHALL update row/line/state only on cycles with enable && endLine; newRow/newFrame SHALL be high exactly on the enabled cycle following that update, else low.
REQ-016 SHALL implement states ROWS and ADJUST.
REQ-017 In ROWS: if line>=reg_ctv, line<=0 and row ends; else line<=line+1.
REQ-018 At row end in ROWS: if row>=reg_vt and reg_vta==0, frame wraps (row<=0); if row>=reg_vt and reg_vta!=0, go to ADJUST, adjust counter<=0; else row<=row+1.
REQ-019 Comparisons SHALL use >= so that reprogramming reg_vt/reg_ctv below the current count ends the row/frame at the next boundary, never runs to 8-bit wrap.
REQ-020 In ADJUST: row holds at reg_vt+1 (8-bit, wraps), line counts 0..reg_vta-1; when adjust counter reaches reg_vta-1, frame wraps.
REQ-021 Frame wrap SHALL set row=0, line=0, state=ROWS, assert newRow and newFrame.
REQ-022 vdispen SHALL set at frame wrap if reg_vd!=0 and clear at the row transition into row==reg_vd; reg_vd==0 keeps it low all frame.
REQ-023 On row transition into row==reg_vp, vsync SHALL arm; vsync SHALL rise at the next hSyncStart and stay high for reg_vw lines (16 if 0), falling at the hSyncStart ending the last line.
REQ-024 If reg_vp>reg_vt, vsync SHALL never assert in that frame.
REQ-025 vblank SHALL equal !vdispen || vsync, registered.
REQ-026 Simultaneous vsync arm and frame wrap (reg_vp==0) SHALL arm vsync in the new frame.

Reset
REQ-027 On reset: row=0, line=0, state=ROWS, adjust counter=0, vsync counter=0, vdispen=0, vsync=0, vblank=1, newRow=0, newFrame=0.
REQ-028 Reset mid-frame or mid-vsync SHALL take effect the next clock regardless of enable; counting resumes from row 0, line 0, with vdispen low until the first frame wrap.

Structure
REQ-029 State enum (ROWS, ADJUST) and register index constants (R3..R9) SHALL live in shared package vdc_pkg.
REQ-030 Vsync width counter SHALL be sub-module vdc_vsync_gen; all else in vdc_signals_v.

Verification
REQ-031 vt=3, ctv=1, vta=0, vd=2: newFrame every 8 lines; vdispen high rows 0-1, low rows 2-3.
REQ-032 vt=3, ctv=1, vta=3: frame = 11 lines; row holds 4 for 3 ADJUST lines, then newFrame.
REQ-033 vp=2, vw=3: vsync rises at first hSyncStart in row 2, high exactly 3 lines; vw=0 gives 16 lines.
REQ-034 Mid-row reg_ctv 7->2 while line=5: next endLine ends row, line=0, row+1.
REQ-035 Assert reset at row 2 line 1 with vsync high: next cycle row=0, line=0, vsync=0, vblank=1.
REQ-036 enable low for 10 cycles spanning endLine pulses: no counter change, no pulses.
